// File: rtl/ce_pulse_sequencer_if.sv
// ce_pulse_sequencer_if
//   Bundles the run-control inputs and pulse outputs of ce_pulse_sequencer.
//   master: the controller that programs the sequencer and watches its outputs.
//   slave:  the sequencer itself.
//   Signals:
//     iEn        run request
//     iMode      00 off, 01 continuous, 10 repeating burst, 11 one-shot burst
//     iPeriod    cycles between pulses (0 behaves as 1)
//     iBurstLen  pulses per burst (0 behaves as 1)
//     iGap       extra idle cycles after each repeating burst
//     oCE        single-cycle clock-enable pulse for the Toggle stage
//     oBurstDone pulse coincident with the last oCE of a burst
//     oBusy      sequencer is actively running (RUN or GAP)
interface ce_pulse_sequencer_if #(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 4
);
  logic               iEn;
  logic [1:0]         iMode;
  logic [CNT_W-1:0]   iPeriod;
  logic [BURST_W-1:0] iBurstLen;
  logic [CNT_W-1:0]   iGap;
  logic               oCE;
  logic               oBurstDone;
  logic               oBusy;

  modport master (
    output iEn, iMode, iPeriod, iBurstLen, iGap,
    input  oCE, oBurstDone, oBusy
  );

  modport slave (
    input  iEn, iMode, iPeriod, iBurstLen, iGap,
    output oCE, oBurstDone, oBusy
  );
endinterface

// File: rtl/ce_pulse_sequencer.sv
// ce_pulse_sequencer
//   Produces the single-cycle clock-enable pulses feeding the iCE input of the
//   Toggle stage: continuous pulsing every P cycles, repeating bursts of N
//   pulses separated by G idle cycles, or a single one-shot burst.
//   Ports:
//     iClk  system clock, rising edge
//     iRst  synchronous active-high reset
//     bus   ce_pulse_sequencer_if.slave (run controls in, oCE/oBurstDone/oBusy out)
module ce_pulse_sequencer #(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 4
) (
  input  logic                   iClk,
  input  logic                   iRst,
  ce_pulse_sequencer_if.slave    bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_CONT = 2'b01;
  localparam logic [1:0] MODE_ONCE = 2'b11;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   pCnt_q, pCnt_d;
  logic [BURST_W-1:0] bCnt_q, bCnt_d;
  logic [CNT_W-1:0]   gCnt_q, gCnt_d;

  // Shadow copies of the run controls; limits are stored as value-1 so that
  // a programmed 0 and a programmed 1 both become a limit of 0.
  logic [1:0]         mode_q, mode_d;
  logic [CNT_W-1:0]   pLim_q, pLim_d;
  logic [BURST_W-1:0] nLim_q, nLim_d;
  logic [CNT_W-1:0]   gap_q, gap_d;

  logic ce_q, ce_d;
  logic done_q, done_d;
  logic busy_q, busy_d;

  logic             runStep;
  logic [CNT_W-1:0] pCur;

  // Next-state logic. A "run step" advances the period counter and may emit a
  // pulse; it happens on every RUN edge and also on the edge that leaves IDLE
  // or GAP, with the period count starting from zero. That is what places the
  // first pulse P cycles after the exit edge.
  always_comb begin
    state_d = state_q;
    pCnt_d  = pCnt_q;
    bCnt_d  = bCnt_q;
    gCnt_d  = gCnt_q;
    mode_d  = mode_q;
    pLim_d  = pLim_q;
    nLim_d  = nLim_q;
    gap_d   = gap_q;
    ce_d    = 1'b0;
    done_d  = 1'b0;
    runStep = 1'b0;
    pCur    = pCnt_q;

    case (state_q)
      IDLE: begin
        if (bus.iEn && (bus.iMode != MODE_OFF)) begin
          mode_d  = bus.iMode;
          pLim_d  = (bus.iPeriod == '0) ? '0 : bus.iPeriod - CNT_W'(1);
          nLim_d  = (bus.iBurstLen == '0) ? '0 : bus.iBurstLen - BURST_W'(1);
          gap_d   = bus.iGap;
          runStep = 1'b1;
          pCur    = '0;
        end
      end
      RUN: runStep = 1'b1;
      GAP: begin
        if (gCnt_q == gap_q) begin
          runStep = 1'b1;
          pCur    = '0;
          gCnt_d  = '0;
        end else begin
          gCnt_d = gCnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase

    if (runStep) begin
      state_d = RUN;
      if (pCur == pLim_d) begin
        ce_d   = 1'b1;
        pCnt_d = '0;
        if (mode_d != MODE_CONT) begin
          if (bCnt_q == nLim_d) begin
            done_d = 1'b1;
            bCnt_d = '0;
            if (mode_d == MODE_ONCE) begin
              state_d = DONE;
            end else if (gap_d != '0) begin
              state_d = GAP;
              gCnt_d  = '0;
            end
          end else begin
            bCnt_d = bCnt_q + BURST_W'(1);
          end
        end
      end else begin
        pCnt_d = pCur + CNT_W'(1);
      end
    end

    // Dropping the run request abandons whatever is in progress.
    if (!bus.iEn) begin
      state_d = IDLE;
      pCnt_d  = '0;
      bCnt_d  = '0;
      gCnt_d  = '0;
      ce_d    = 1'b0;
      done_d  = 1'b0;
    end

    // The last pulse of a one-shot burst still counts as busy even though
    // the state has already moved to DONE.
    busy_d = ce_d | (state_d == RUN) | (state_d == GAP);
  end

  // State, counters, shadow controls and registered outputs.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= IDLE;
      pCnt_q  <= '0;
      bCnt_q  <= '0;
      gCnt_q  <= '0;
      mode_q  <= MODE_OFF;
      pLim_q  <= '0;
      nLim_q  <= '0;
      gap_q   <= '0;
      ce_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pCnt_q  <= pCnt_d;
      bCnt_q  <= bCnt_d;
      gCnt_q  <= gCnt_d;
      mode_q  <= mode_d;
      pLim_q  <= pLim_d;
      nLim_q  <= nLim_d;
      gap_q   <= gap_d;
      ce_q    <= ce_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.oCE        = ce_q;
  assign bus.oBurstDone = done_q;
  assign bus.oBusy      = busy_q;

endmodule

// File: tb/tb_ce_pulse_sequencer.sv
// tb_ce_pulse_sequencer
//   Drives ce_pulse_sequencer through each operating mode and compares
//   {oCE, oBurstDone, oBusy} every cycle against a cycle-index model.
module tb_ce_pulse_sequencer;

  logic iClk = 1'b0;
  logic iRst;

  always #5 iClk = ~iClk;

  ce_pulse_sequencer_if #(.CNT_W(16), .BURST_W(4)) bus ();

  ce_pulse_sequencer #(.CNT_W(16), .BURST_W(4)) dut (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [2:0] obs;
  assign obs = {bus.oCE, bus.oBurstDone, bus.oBusy};

  // Inputs change on the falling edge so they are stable at the rising edge.
  task automatic applyStimulus(input logic en, input int mode, input int p,
                               input int n, input int g);
    bus.iEn       = en;
    bus.iMode     = 2'(mode);
    bus.iPeriod   = 16'(p);
    bus.iBurstLen = 4'(n);
    bus.iGap      = 16'(g);
  endtask

  // Expected {oCE, oBurstDone, oBusy} for cycle c (c=1 is the cycle right
  // after the edge that leaves IDLE). A repeating burst is a frame of
  // N*P pulse cycles plus G gap cycles; a one-shot is a single such burst.
  function automatic logic [2:0] modelOut(input int mode, input int p,
                                          input int n, input int g,
                                          input int c);
    int pe, ne, len, r;
    logic ce, dn, bz;
    pe = (p == 0) ? 1 : p;
    ne = (n == 0) ? 1 : n;
    ce = 1'b0; dn = 1'b0; bz = 1'b0;
    case (mode)
      1: begin
        ce = (c % pe) == 0;
        bz = 1'b1;
      end
      2: begin
        len = ne * pe + g;
        r   = ((c - 1) % len) + 1;
        ce  = ((r % pe) == 0) && (r <= ne * pe);
        dn  = (r == ne * pe);
        bz  = 1'b1;
      end
      3: begin
        ce = ((c % pe) == 0) && (c <= ne * pe);
        dn = (c == ne * pe);
        bz = (c <= ne * pe);
      end
      default: ;
    endcase
    return {ce, dn, bz};
  endfunction

  task automatic test_reset;
    iRst = 1'b1;
    applyStimulus(1'b1, 1, 1, 1, 0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge iClk);
      checks++;
      if (obs !== 3'b000) begin
        errors++;
        $display("[TB] FAIL reset_priority c=%0d got %b expected 000", c, obs);
      end
    end
    iRst = 1'b0;
    applyStimulus(1'b0, 0, 0, 0, 0);
    @(negedge iClk);
    checks++;
    if (obs !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_release got %b expected 000", obs);
    end
  endtask

  task automatic test_mode_off;
    logic [2:0] exp;
    applyStimulus(1'b1, 0, 1, 1, 0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge iClk);
      exp = modelOut(0, 1, 1, 0, c);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL mode_off c=%0d got %b expected %b", c, obs, exp);
      end
    end
    applyStimulus(1'b0, 0, 0, 0, 0);
    @(negedge iClk);
  endtask

  task automatic test_continuous;
    int periods[3] = '{4, 0, 1};
    int lens[3]    = '{14, 6, 6};
    logic [2:0] exp;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1, periods[k], 0, 0);
      for (int c = 1; c <= lens[k]; c++) begin
        @(negedge iClk);
        exp = modelOut(1, periods[k], 0, 0, c);
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("[TB] FAIL continuous P=%0d c=%0d got %b expected %b",
                   periods[k], c, obs, exp);
        end
      end
      applyStimulus(1'b0, 1, periods[k], 0, 0);
      @(negedge iClk);
      checks++;
      if (obs !== 3'b000) begin
        errors++;
        $display("[TB] FAIL continuous_stop P=%0d got %b expected 000", periods[k], obs);
      end
    end
  endtask

  task automatic test_repeat_burst;
    int gaps[2] = '{5, 0};
    logic [2:0] exp;
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 2, 3, 2, gaps[k]);
      for (int c = 1; c <= 30; c++) begin
        @(negedge iClk);
        exp = modelOut(2, 3, 2, gaps[k], c);
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("[TB] FAIL repeat_burst G=%0d c=%0d got %b expected %b",
                   gaps[k], c, obs, exp);
        end
      end
      applyStimulus(1'b0, 0, 0, 0, 0);
      @(negedge iClk);
    end
  endtask

  task automatic test_one_shot;
    logic [2:0] exp;
    int ps[3] = '{2, 1, 2};
    int ns[3] = '{3, 15, 0};
    for (int k = 0; k < 3; k++) begin
      // Run twice: the second pass proves iEn low then high re-arms it.
      for (int pass = 0; pass < 2; pass++) begin
        applyStimulus(1'b1, 3, ps[k], ns[k], 0);
        for (int c = 1; c <= 22; c++) begin
          @(negedge iClk);
          exp = modelOut(3, ps[k], ns[k], 0, c);
          checks++;
          if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL one_shot P=%0d N=%0d pass=%0d c=%0d got %b expected %b",
                     ps[k], ns[k], pass, c, obs, exp);
          end
        end
        applyStimulus(1'b0, 3, ps[k], ns[k], 0);
        @(negedge iClk);
      end
    end
  endtask

  task automatic test_shadow;
    logic [2:0] exp;
    applyStimulus(1'b1, 2, 3, 2, 1);
    for (int c = 1; c <= 24; c++) begin
      @(negedge iClk);
      exp = modelOut(2, 3, 2, 1, c);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL shadow_hold c=%0d got %b expected %b", c, obs, exp);
      end
      if (c == 4) applyStimulus(1'b1, 1, 7, 5, 3);
    end
    applyStimulus(1'b0, 2, 7, 5, 3);
    @(negedge iClk);
    applyStimulus(1'b1, 2, 7, 5, 3);
    for (int c = 1; c <= 40; c++) begin
      @(negedge iClk);
      exp = modelOut(2, 7, 5, 3, c);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL shadow_reload c=%0d got %b expected %b", c, obs, exp);
      end
    end
    applyStimulus(1'b0, 0, 0, 0, 0);
    @(negedge iClk);
  endtask

  task automatic test_abort;
    logic [2:0] exp;
    // Enable dropped after the first of four pulses.
    applyStimulus(1'b1, 2, 3, 4, 2);
    for (int c = 1; c <= 3; c++) begin
      @(negedge iClk);
      exp = modelOut(2, 3, 4, 2, c);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL abort_pre c=%0d got %b expected %b", c, obs, exp);
      end
    end
    applyStimulus(1'b0, 2, 3, 4, 2);
    for (int c = 1; c <= 4; c++) begin
      @(negedge iClk);
      checks++;
      if (obs !== 3'b000) begin
        errors++;
        $display("[TB] FAIL abort_idle c=%0d got %b expected 000", c, obs);
      end
    end
    applyStimulus(1'b1, 2, 5, 4, 2);
    for (int c = 1; c <= 30; c++) begin
      @(negedge iClk);
      exp = modelOut(2, 5, 4, 2, c);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL abort_restart c=%0d got %b expected %b", c, obs, exp);
      end
    end

    // Reset asserted in the middle of a gap.
    applyStimulus(1'b0, 0, 0, 0, 0);
    @(negedge iClk);
    applyStimulus(1'b1, 2, 3, 2, 5);
    for (int c = 1; c <= 8; c++) begin
      @(negedge iClk);
      exp = modelOut(2, 3, 2, 5, c);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL gap_pre c=%0d got %b expected %b", c, obs, exp);
      end
    end
    iRst = 1'b1;
    @(negedge iClk);
    checks++;
    if (obs !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_mid_gap got %b expected 000", obs);
    end
    iRst = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge iClk);
      exp = modelOut(2, 3, 2, 5, c);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL gap_restart c=%0d got %b expected %b", c, obs, exp);
      end
    end
    applyStimulus(1'b0, 0, 0, 0, 0);
    @(negedge iClk);
  endtask

  task automatic test_random;
    int mode, p, n, g, len, scramble;
    logic [2:0] exp;
    for (int it = 0; it < 25; it++) begin
      mode     = int'($urandom_range(0, 3));
      p        = int'($urandom_range(0, 6));
      n        = int'($urandom_range(0, 5));
      g        = int'($urandom_range(0, 4));
      len      = int'($urandom_range(1, 40));
      scramble = int'($urandom_range(1, 40));
      applyStimulus(1'b1, mode, p, n, g);
      for (int c = 1; c <= len; c++) begin
        @(negedge iClk);
        exp = modelOut(mode, p, n, g, c);
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("[TB] FAIL random it=%0d m=%0d P=%0d N=%0d G=%0d c=%0d got %b expected %b",
                   it, mode, p, n, g, c, obs, exp);
        end
        if (c == scramble && mode != 0)
          applyStimulus(1'b1, int'($urandom_range(1, 3)), int'($urandom_range(0, 9)),
                        int'($urandom_range(0, 15)), int'($urandom_range(0, 9)));
      end
      applyStimulus(1'b0, 0, 0, 0, 0);
      @(negedge iClk);
      checks++;
      if (obs !== 3'b000) begin
        errors++;
        $display("[TB] FAIL random_stop it=%0d got %b expected 000", it, obs);
      end
    end
  endtask

  initial begin
    #2000000;
    errors++;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    iRst = 1'b1;
    applyStimulus(1'b0, 0, 0, 0, 0);
    @(negedge iClk);
    test_reset();
    test_mode_off();
    test_continuous();
    test_repeat_burst();
    test_one_shot();
    test_shadow();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
